vga_dac_controller: RTL and testbench
=====================================

VGA_DAC_CONTROLLER -- requirements
Module: vga_dac_controller

Interface
REQ-001 Parameter BPC, default 8, bits per colour channel; SHALL be a multiple of SEG.
REQ-002 Parameter SEG, default 2, bits per thermometer segment; each segment yields 2^SEG-1 lines.
REQ-003 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in clocks.
REQ-004 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-005 Parameter SYNC_POL, default 0, asserted sync level (0 = active-low).
REQ-006 clk  input  1  pixel clock; one clock only.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 rst_vga_mask  input  1  when high, rst does not clear the timing counters.
REQ-009 mode  input  2  pattern select: 0 solid, 1 gradient, 2 xor, 3 scroll.
REQ-010 solid_rgb  input  3*BPC  colour for mode 0, packed {r,g,b}.
REQ-011 r, g, b  output  BPC each  pixel value; rn, gn, bn  output  BPC each  bitwise complements.
REQ-012 r_th, g_th, b_th  output  (BPC/SEG)*(2^SEG-1) each  segmented thermometer code of r/g/b.
REQ-013 hsync, vsync  output  1  syncs; hblank, vblank  output  1  active-high blanking flags.
REQ-014 frame  output  8  frame counter.

Function
REQ-015 H_TOTAL = sum of H params and V_TOTAL = sum of V params SHALL be derived from parameters and never reprogrammed at runtime.
REQ-016 h counts 0..H_TOTAL-1; at H_TOTAL-1 it wraps to 0 and v increments; at v = V_TOTAL-1 with h wrap, v wraps to 0.
REQ-017 frame increments by 1 (mod 256) when h and v both wrap simultaneously.
REQ-018 Internal sync active when h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync likewise on v; output level = SYNC_POL when active, else inverse.
REQ-019 hblank = (h >= H_ACTIVE); vblank = (v >= V_ACTIVE).
REQ-020 All outputs SHALL be registered; every output at cycle k+1 reflects h, v, frame, active mode at cycle k (1-cycle latency, all mutually aligned).
REQ-021 mode and solid_rgb SHALL be sampled only when h=0 and v=0; changes mid-frame take effect at the next frame start.
REQ-022 Pattern, with x = h and y = v truncated/zero-extended to BPC: mode 0 r,g,b = solid_rgb; mode 1 r = x, g = y, b = BPC'0; mode 2 r = g = b = x XOR y; mode 3 r = x + frame, g = y + frame, b = x XOR frame (mod 2^BPC, frame zero-extended/truncated).
REQ-023 r, g, b SHALL be forced to 0 whenever hblank or vblank is high; rn, gn, bn then all ones.
REQ-024 Thermometer: for segment s (bits [SEG*s+SEG-1 : SEG*s]) of value n, line i of that segment's group is 1 iff i < n; segment s occupies bits [(2^SEG-1)*(s+1)-1 : (2^SEG-1)*s].

Reset
REQ-025 rst high with rst_vga_mask low SHALL clear h, v, frame to 0 and latched mode to 0, latched solid_rgb to 0.
REQ-026 rst high with rst_vga_mask high SHALL clear only latched mode/solid_rgb and frame; h and v keep counting.
REQ-027 During rst and the cycle after, outputs: r,g,b = 0; rn,gn,bn all ones; *_th = 0; hsync, vsync inactive; hblank, vblank = 0.
REQ-028 rst asserted mid-line SHALL take effect at the next clock edge with no partial-line completion.

Structure
REQ-029 Package vga_dac_pkg SHALL hold the mode enum, thermometer width function, and default timing constants.
REQ-030 One sub-module thermo_enc (one SEG-bit segment to 2^SEG-1 lines, combinational) SHALL be instantiated per segment per channel.

Verification
REQ-031 Defaults, mode 0, after reset -> hsync low exactly 96 clocks every 800 clocks; first hsync fall 657 clocks after reset release.
REQ-032 Defaults -> vsync low for 1600 clocks every 420000 clocks; frame = 1 after first 420000 clocks.
REQ-033 Mode 0, solid_rgb = 0xFF8003 -> active pixels r = 0xFF, g = 0x80, b = 0x03, b_th = 12'b000000000111; r_th all ones; during blanking r = 0, rn = 0xFF.
REQ-034 Mode 1 at h = 300, v = 5 -> r = 0x2C, g = 0x05, b = 0x00 one clock later.
REQ-035 mode changed 1->2 at h = 100, v = 10 -> pattern remains gradient until next h = 0, v = 0, then xor.
REQ-036 rst pulsed with rst_vga_mask high at h = 400 -> h continues 401, 402..., frame = 0, mode reverts to 0 until next frame start.

Source files
------------

// File: rtl/vga_dac_pkg.sv
// Shared types and defaults for the VGA DAC controller: pattern modes,
// default 640x480 timing and the thermometer bus width helper.
package vga_dac_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_GRADIENT = 2'd1,
    MODE_XOR      = 2'd2,
    MODE_SCROLL   = 2'd3
  } mode_e;

  localparam int DEF_BPC      = 8;
  localparam int DEF_SEG      = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Each SEG-bit segment expands to 2^SEG-1 thermometer lines.
  function automatic int thermo_width(input int bpc, input int seg);
    return (bpc / seg) * ((32'sd1 <<< seg) - 32'sd1);
  endfunction

endpackage

// File: rtl/vga_dac_controller_if.sv
// Pattern-control inputs and DAC/sync outputs of the VGA DAC controller.
// The controller uses the slave view; the pattern source/monitor uses master.
interface vga_dac_controller_if #(
  parameter int BPC = 8,
  parameter int SEG = 2
);
  import vga_dac_pkg::*;

  localparam int TW = thermo_width(BPC, SEG);

  logic [1:0]       mode;
  logic [3*BPC-1:0] solid_rgb;
  logic [BPC-1:0]   r, g, b;
  logic [BPC-1:0]   rn, gn, bn;
  logic [TW-1:0]    r_th, g_th, b_th;
  logic             hsync, vsync;
  logic             hblank, vblank;
  logic [7:0]       frame;

  modport master (
    output mode, solid_rgb,
    input  r, g, b, rn, gn, bn, r_th, g_th, b_th,
    input  hsync, vsync, hblank, vblank, frame
  );

  modport slave (
    input  mode, solid_rgb,
    output r, g, b, rn, gn, bn, r_th, g_th, b_th,
    output hsync, vsync, hblank, vblank, frame
  );

endinterface

// File: rtl/vga_dac_controller_thermo_enc.sv
// One SEG-bit binary segment to its 2^SEG-1 line thermometer code.
module thermo_enc #(
  parameter  int SEG   = 2,
  localparam int LINES = (32'sd1 <<< SEG) - 32'sd1
) (
  input  logic [SEG-1:0]   seg_val,
  output logic [LINES-1:0] lines
);

  // Line i is lit while i is below the segment value.
  always_comb begin
    lines = '0;
    for (int i = 0; i < LINES; i++) begin
      lines[i] = (SEG'(i) < seg_val);
    end
  end

endmodule

// File: rtl/vga_dac_controller.sv
// VGA timing generator with test-pattern source and segmented thermometer
// DAC drive; every output is registered with one clock of latency.
module vga_dac_controller
  import vga_dac_pkg::*;
#(
  parameter int BPC      = DEF_BPC,
  parameter int SEG      = DEF_SEG,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input logic clk,
  input logic rst,
  input logic rst_vga_mask,
  vga_dac_controller_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int NSEG    = BPC / SEG;
  localparam int LPS     = (32'sd1 <<< SEG) - 32'sd1;
  localparam int TW      = thermo_width(BPC, SEG);

  logic [HW-1:0]          h_r;
  logic [VW-1:0]          v_r;
  logic [7:0]             frame_r;
  mode_e                  mode_r;
  logic [3*BPC-1:0]       solid_r;

  logic                   h_wrap_s, v_wrap_s, frame_start_s;
  mode_e                  eff_mode_s;
  logic [3*BPC-1:0]       eff_solid_s;
  logic [BPC-1:0]         x_s, y_s, f_s;
  logic [2:0][BPC-1:0]    pix_raw_s, pix_s;
  logic [2:0][TW-1:0]     th_s;
  logic                   hblank_s, vblank_s, hsync_act_s, vsync_act_s;

  logic [2:0][BPC-1:0]    pix_r, pixn_r;
  logic [2:0][TW-1:0]     th_r;
  logic                   hsync_r, vsync_r, hblank_r, vblank_r;
  logic [7:0]             frame_out_r;

  assign h_wrap_s      = (h_r == HW'(H_TOTAL - 1));
  assign v_wrap_s      = (v_r == VW'(V_TOTAL - 1));
  assign frame_start_s = (h_r == '0) && (v_r == '0);

  // The first pixel of a frame already uses the freshly sampled controls.
  assign eff_mode_s  = frame_start_s ? mode_e'(bus.mode) : mode_r;
  assign eff_solid_s = frame_start_s ? bus.solid_rgb : solid_r;

  assign x_s = BPC'(h_r);
  assign y_s = BPC'(v_r);
  assign f_s = BPC'(frame_r);

  assign hblank_s    = (h_r >= HW'(H_ACTIVE));
  assign vblank_s    = (v_r >= VW'(V_ACTIVE));
  assign hsync_act_s = (h_r >= HW'(H_ACTIVE + H_FP)) && (h_r <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign vsync_act_s = (v_r >= VW'(V_ACTIVE + V_FP)) && (v_r <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));

  // Horizontal/vertical position; the mask lets the raster free-run through reset.
  always_ff @(posedge clk) begin
    if (rst && !rst_vga_mask) begin
      h_r <= '0;
      v_r <= '0;
    end else if (h_wrap_s) begin
      h_r <= '0;
      v_r <= v_wrap_s ? '0 : v_r + VW'(1);
    end else begin
      h_r <= h_r + HW'(1);
    end
  end

  // Frame counter and frame-start latch of the pattern controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_r <= 8'd0;
      mode_r  <= MODE_SOLID;
      solid_r <= '0;
    end else begin
      if (h_wrap_s && v_wrap_s) begin
        frame_r <= frame_r + 8'd1;
      end
      if (frame_start_s) begin
        mode_r  <= mode_e'(bus.mode);
        solid_r <= bus.solid_rgb;
      end
    end
  end

  // Pattern generator; channel 2 is red, 1 green, 0 blue.
  always_comb begin
    pix_raw_s = '0;
    case (eff_mode_s)
      MODE_SOLID:    pix_raw_s = eff_solid_s;
      MODE_GRADIENT: pix_raw_s = {x_s, y_s, {BPC{1'b0}}};
      MODE_XOR:      pix_raw_s = {3{x_s ^ y_s}};
      MODE_SCROLL:   pix_raw_s = {x_s + f_s, y_s + f_s, x_s ^ f_s};
      default:       pix_raw_s = '0;
    endcase
  end

  assign pix_s = (hblank_s || vblank_s) ? '0 : pix_raw_s;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    for (genvar s = 0; s < NSEG; s++) begin : g_seg
      thermo_enc #(.SEG(SEG)) u_enc (
        .seg_val (pix_s[c][SEG*s +: SEG]),
        .lines   (th_s[c][LPS*s +: LPS])
      );
    end
  end

  // Output register stage, all outputs aligned to the same raster position.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_r       <= '0;
      pixn_r      <= '1;
      th_r        <= '0;
      hsync_r     <= ~SYNC_POL;
      vsync_r     <= ~SYNC_POL;
      hblank_r    <= 1'b0;
      vblank_r    <= 1'b0;
      frame_out_r <= 8'd0;
    end else begin
      pix_r       <= pix_s;
      pixn_r      <= ~pix_s;
      th_r        <= th_s;
      hsync_r     <= hsync_act_s ? SYNC_POL : ~SYNC_POL;
      vsync_r     <= vsync_act_s ? SYNC_POL : ~SYNC_POL;
      hblank_r    <= hblank_s;
      vblank_r    <= vblank_s;
      frame_out_r <= frame_r;
    end
  end

  assign bus.r      = pix_r[2];
  assign bus.g      = pix_r[1];
  assign bus.b      = pix_r[0];
  assign bus.rn     = pixn_r[2];
  assign bus.gn     = pixn_r[1];
  assign bus.bn     = pixn_r[0];
  assign bus.r_th   = th_r[2];
  assign bus.g_th   = th_r[1];
  assign bus.b_th   = th_r[0];
  assign bus.hsync  = hsync_r;
  assign bus.vsync  = vsync_r;
  assign bus.hblank = hblank_r;
  assign bus.vblank = vblank_r;
  assign bus.frame  = frame_out_r;

endmodule

// File: tb/tb_vga_dac_controller.sv
// Self-checking bench for vga_dac_controller on a reduced raster, checked
// every clock against a position/frame reference model.
module tb_vga_dac_controller;

  localparam int BPC  = 8;
  localparam int SEG  = 2;
  localparam int HA   = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA   = 20, VF = 2, VS = 2, VB = 3;
  localparam int HT   = HA + HF + HS + HB;
  localparam int VT   = VA + VF + VS + VB;
  localparam int FT   = HT * VT;
  localparam int NSEG = BPC / SEG;
  localparam int LPS  = (1 << SEG) - 1;
  localparam int TW   = NSEG * LPS;
  localparam int PMAX = 1 << BPC;

  logic clk = 1'b0;
  logic rst;
  logic rst_vga_mask;

  vga_dac_controller_if #(.BPC(BPC), .SEG(SEG)) bus ();

  vga_dac_controller #(
    .BPC(BPC), .SEG(SEG),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rst_vga_mask (rst_vga_mask),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pixel clocks since counter reset, plus frame/latched controls.
  int m_t = 0;
  int m_frame = 0;
  int m_mode = 0;
  int m_solid = 0;

  logic [3*BPC-1:0] e_rgb, e_rgbn;
  logic [3*TW-1:0]  e_th;
  logic [11:0]      e_misc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] therm(input int val);
    logic [TW-1:0] res;
    int n;
    res = '0;
    for (int s = 0; s < NSEG; s++) begin
      n = (val >> (SEG * s)) & LPS;
      for (int i = 0; i < n; i++) res[s*LPS + i] = 1'b1;
    end
    return res;
  endfunction

  function automatic int pos_h();
    return m_t % HT;
  endfunction

  function automatic int pos_v();
    return (m_t / HT) % VT;
  endfunction

  task automatic predict();
    int h, v, md, sol, x, y, f, r, g, b;
    bit hb, vb, hs, vs;
    if (rst) begin
      e_rgb  = '0;
      e_rgbn = '1;
      e_th   = '0;
      e_misc = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    end else begin
      h = pos_h();
      v = pos_v();
      if (h == 0 && v == 0) begin
        md  = int'(bus.mode);
        sol = int'(bus.solid_rgb);
      end else begin
        md  = m_mode;
        sol = m_solid;
      end
      x = h % PMAX;
      y = v % PMAX;
      f = m_frame % PMAX;
      case (md)
        0: begin r = (sol >> (2*BPC)) % PMAX; g = (sol >> BPC) % PMAX; b = sol % PMAX; end
        1: begin r = x; g = y; b = 0; end
        2: begin r = x ^ y; g = r; b = r; end
        default: begin r = (x + f) % PMAX; g = (y + f) % PMAX; b = x ^ f; end
      endcase
      hb = (h >= HA);
      vb = (v >= VA);
      if (hb || vb) begin r = 0; g = 0; b = 0; end
      hs = !(h >= HA + HF && h < HA + HF + HS);
      vs = !(v >= VA + VF && v < VA + VF + VS);
      e_rgb  = {BPC'(r), BPC'(g), BPC'(b)};
      e_rgbn = ~e_rgb;
      e_th   = {therm(r), therm(g), therm(b)};
      e_misc = {hs, vs, hb, vb, 8'(m_frame)};
    end
  endtask

  task automatic advance();
    bit fs;
    fs = (pos_h() == 0 && pos_v() == 0);
    if (rst) begin
      m_frame = 0;
      m_mode  = 0;
      m_solid = 0;
    end else begin
      if (m_t % FT == FT - 1) m_frame = (m_frame + 1) % 256;
      if (fs) begin
        m_mode  = int'(bus.mode);
        m_solid = int'(bus.solid_rgb);
      end
    end
    if (rst && !rst_vga_mask) m_t = 0;
    else m_t++;
  endtask

  task automatic tick();
    predict();
    advance();
    @(posedge clk);
    #1;
    check("rgb", {bus.r, bus.g, bus.b}, e_rgb);
    check("rgb_n", {bus.rn, bus.gn, bus.bn}, e_rgbn);
    check("thermo", {bus.r_th, bus.g_th, bus.b_th}, e_th);
    check("sync_blank_frame", {bus.hsync, bus.vsync, bus.hblank, bus.vblank, bus.frame}, e_misc);
  endtask

  // Advance until the model sits at (th, tv), so the next tick shows that pixel.
  task automatic run_until(input int th, input int tv);
    int k;
    k = 0;
    while (!(pos_h() == th && pos_v() == tv) && k < 2 * FT) begin
      tick();
      k++;
    end
    check("run_until_bound", 64'(k < 2 * FT), 64'd1);
  endtask

  initial begin
    int first_fall, hs_low, vs_low;
    logic prev_hs;

    rst          = 1'b1;
    rst_vga_mask = 1'b0;
    bus.mode      = 2'd0;
    bus.solid_rgb = 24'hFF8003;
    for (int i = 0; i < 3; i++) tick();
    check("reset_r", 64'(bus.r), 64'd0);
    check("reset_rn", 64'(bus.rn), 64'hFF);

    // One full frame of solid colour: sync timing and colour checks.
    rst = 1'b0;
    first_fall = -1;
    hs_low = 0;
    vs_low = 0;
    prev_hs = 1'b1;
    for (int k = 1; k <= FT; k++) begin
      tick();
      if (k == 1) begin
        check("solid_r", 64'(bus.r), 64'hFF);
        check("solid_g", 64'(bus.g), 64'h80);
        check("solid_b", 64'(bus.b), 64'h03);
        check("solid_b_th", 64'(bus.b_th), 64'(12'b000000000111));
        check("solid_r_th", 64'(bus.r_th), 64'hFFF);
      end
      if (k == HA + 1) begin
        check("blank_r", 64'(bus.r), 64'd0);
        check("blank_rn", 64'(bus.rn), 64'hFF);
      end
      if (prev_hs && !bus.hsync && first_fall < 0) first_fall = k;
      prev_hs = bus.hsync;
      if (!bus.hsync) hs_low++;
      if (!bus.vsync) vs_low++;
    end
    check("first_hsync_fall", 64'(first_fall), 64'(HA + HF + 1));
    check("hsync_low_per_frame", 64'(hs_low), 64'(HS * VT));
    check("vsync_low_per_frame", 64'(vs_low), 64'(VS * HT));
    tick();
    check("frame_after_one", 64'(bus.frame), 64'd1);

    // Gradient mode, requested mid-frame.
    bus.mode = 2'd1;
    run_until(0, 0);
    run_until(30, 5);
    tick();
    check("grad_r", 64'(bus.r), 64'h1E);
    check("grad_g", 64'(bus.g), 64'h05);
    check("grad_b", 64'(bus.b), 64'h00);

    // Gradient to xor mid-frame only switches at the next frame start.
    run_until(10, 10);
    bus.mode = 2'd2;
    run_until(5, 15);
    tick();
    check("still_gradient", 64'(bus.r), 64'd5);
    run_until(5, 15);
    tick();
    check("now_xor", 64'(bus.r), 64'(5 ^ 15));

    // Scroll mode with a random colour parked on the solid input.
    bus.mode = 2'd3;
    bus.solid_rgb = 24'($urandom);
    for (int i = 0; i < 2 * FT; i++) tick();

    // Masked reset mid-line: raster keeps running, frame and mode clear.
    run_until(40, 3);
    rst = 1'b1;
    rst_vga_mask = 1'b1;
    tick();
    rst = 1'b0;
    rst_vga_mask = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("masked_h_continues_hsync", 64'(bus.hsync), 64'd0);
    check("masked_frame_zero", 64'(bus.frame), 64'd0);
    run_until(10, 5);
    tick();
    check("masked_mode_reverted", 64'({bus.r, bus.g}), 64'd0);
    run_until(10, 5);
    tick();
    check("scroll_after_frame", 64'(bus.r), 64'd11);

    // Unmasked reset mid-line, then randomized controls and reset pulses.
    run_until(25, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6 * FT; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        bus.mode      = 2'($urandom_range(0, 3));
        bus.solid_rgb = 24'($urandom);
      end
      if ($urandom_range(0, 2999) == 0) begin
        rst          = 1'b1;
        rst_vga_mask = 1'($urandom_range(0, 1));
      end else begin
        rst          = 1'b0;
        rst_vga_mask = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
